branch_sequencer: RTL and testbench
===================================

// Module: branch_sequencer
// PURPOSE
//  SPARC PC/nPC sequencer with delayed-branch and annul semantics; consumer of the branch target adder (PC + 4*sext(disp)).
//  Per instruction step: evaluates Bicc conditions against icc and strobes the adder (baux) for taken Bicc/CALL.
//  Captures the returned target and updates PC/nPC; flags squash of the delay slot. Sits between fetch and the branch target adder.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value after reset; nPC resets to RESET_PC+4
//  TGT_WAIT  1              cycles after baux pulse before target is captured (>=1)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  step         in   1   advance one instruction; honoured only when ready=1
//  ready        out  1   sequencer idle, step accepted
//  is_bicc      in   1   instruction at pc is Bicc
//  is_call      in   1   instruction at pc is CALL
//  is_jmpl      in   1   instruction at pc is JMPL
//  cond         in   4   Bicc cond field
//  a_bit        in   1   Bicc annul bit
//  icc          in   4   {N,Z,V,C}, sampled at accepted step
//  jmpl_target  in   32  JMPL computed address
//  target       in   32  branch target adder result
//  baux         out  1   one-cycle strobe to adder
//  disp_sel     out  1   1=disp30 (CALL), 0=disp22 (Bicc); held through the target transaction
//  pc           out  32  current PC; also adder in_pc, stable while ready=0
//  npc          out  32  next PC
//  annul        out  1   instruction now at pc must be squashed
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, npc=RESET_PC+4, annul=0, baux=0, disp_sel=0, ready=1, state=RUN; any pending transaction dropped.
//  States: RUN -> CALC -> WAIT -> RUN. Only RUN has ready=1.
//  Condition taken (cond): 0 never, 1 Z, 2 Z|(N^V), 3 N^V, 4 C|Z, 5 C, 6 N, 7 V; 8 always; 9..F are complements of 1..7 (9=~Z ... F=~V).
//  Decode priority when flags collide: annul > is_call > is_jmpl > is_bicc > plain.
//  Accepted step in RUN, 1-cycle cases (stay RUN, next edge):
//   - annul=1: instruction treated as nop, flags ignored; pc<=npc, npc<=npc+4, annul<=0.
//   - plain: pc<=npc, npc<=npc+4, annul<=0.
//   - JMPL: pc<=npc, npc<={jmpl_target[31:2],2'b00}, annul<=0.
//   - Bicc not taken: pc<=npc, npc<=npc+4, annul<=a_bit.
//  Taken Bicc or CALL: latch taken/a_bit/cond; disp_sel<=is_call; go to CALC.
//   - CALC: baux=1 exactly one cycle, pc held; then WAIT.
//   - WAIT: baux=0 for TGT_WAIT cycles; on last cycle, target is captured.
//   - Capture: pc<=npc, npc<=target, annul<=(a_bit & cond==4'h8 & Bicc); CALL never annuls; back to RUN.
//   - Latency: step at cycle 0 -> ready again cycle 2+TGT_WAIT.
//  Arithmetic: npc+4 is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
//  step while ready=0: ignored, no queueing. Input flags are sampled only at the accepted step.
//  Reset asserted in CALC/WAIT: baux drops immediately; no partial PC update.
// TESTING
//  reset, RESET_PC=0, 3 plain steps -> pc 0,4,8,C; npc always pc+4; ready stays 1.
//  BNE (cond=9, a=0) with Z=0 at pc=8, target=0x40:
//   -> one baux pulse, disp_sel=0; after capture pc=C, npc=40, annul=0.
//  BE (cond=1, a=1) with Z=0 -> no baux, 1 cycle; annul=1; next step squashes C and clears annul.
//  BA a=1 (taken, target=0x100) -> annul=1 after capture.
//   - Next step: pc=100, npc=104; a stray is_bicc during that annulled step is ignored.
//  CALL at pc=0x20, target=0x2000 -> disp_sel=1 with baux.
//   - Capture: pc=24, npc=2000, annul=0.
//   - step during CALC/WAIT: ignored, pc unchanged.
//  reset during WAIT -> baux=0, pc=RESET_PC, npc=RESET_PC+4, ready=1.
//  npc wrap: from pc=FFFF_FFF8, plain steps -> npc wraps 0, no X.

Source files
------------

// File: rtl/branch_sequencer_if.sv
// Fetch-side handshake and branch-target-adder signals of the SPARC PC/nPC sequencer.
// The master drives instruction info and the adder result; the slave is the sequencer.
interface branch_sequencer_if;
  // Handshake: a step is taken on a rising clk edge where step && ready.
  // ready is high only when the sequencer is idle. A step while ready is low is
  // dropped, not queued. Instruction flags, cond, a_bit, icc and jmpl_target are
  // sampled only on that edge. target must be valid on the last adder-wait cycle.
  logic        step;
  logic        ready;
  logic        is_bicc;
  logic        is_call;
  logic        is_jmpl;
  logic [3:0]  cond;
  logic        a_bit;
  logic [3:0]  icc;
  logic [31:0] jmpl_target;
  logic [31:0] target;
  logic        baux;
  logic        disp_sel;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        annul;
  logic [1:0]  state;

  modport master (
    output step, is_bicc, is_call, is_jmpl, cond, a_bit, icc, jmpl_target, target,
    input  ready, baux, disp_sel, pc, npc, annul, state
  );

  modport slave (
    input  step, is_bicc, is_call, is_jmpl, cond, a_bit, icc, jmpl_target, target,
    output ready, baux, disp_sel, pc, npc, annul, state
  );
endinterface

// File: rtl/branch_sequencer.sv
// SPARC PC/nPC sequencer with delayed branches and annulled delay slots.
// Taken Bicc and CALL go through the external target adder via a baux strobe.
module branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TGT_WAIT = 1
) (
  input logic               clk,
  input logic               reset,
  branch_sequencer_if.slave bus
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int             CW        = (TGT_WAIT > 1) ? $clog2(TGT_WAIT) : 1;
  localparam logic [CW-1:0]  WAIT_LOAD = CW'(TGT_WAIT - 1);

  logic [1:0]    state;
  logic [31:0]   pc_q;
  logic [31:0]   npc_q;
  logic          annul_q;
  logic          disp_sel_q;
  logic          lat_a;
  logic          lat_bicc;
  logic [3:0]    lat_cond;
  logic [CW-1:0] wait_cnt;

  logic          bicc_taken;
  logic [31:0]   npc_inc;
  logic [31:0]   jmpl_aligned;

  // Low three cond bits pick a base test; cond[3] inverts it (8 = always, 0 = never).
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] flags);
    logic n, z, v, cy, base;
    {n, z, v, cy} = flags;
    case (c[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z;
      3'd2:    base = z | (n ^ v);
      3'd3:    base = n ^ v;
      3'd4:    base = cy | z;
      3'd5:    base = cy;
      3'd6:    base = n;
      default: base = v;
    endcase
    return base ^ c[3];
  endfunction

  always_comb begin
    bicc_taken   = cond_eval(bus.cond, bus.icc);
    npc_inc      = npc_q + 32'd4;
    jmpl_aligned = bus.jmpl_target & ~32'h0000_0003;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC + 32'd4;
      annul_q    <= 1'b0;
      disp_sel_q <= 1'b0;
      lat_a      <= 1'b0;
      lat_bicc   <= 1'b0;
      lat_cond   <= 4'h0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.step) begin
            if (annul_q) begin
              // Squashed delay slot: decode ignored entirely.
              pc_q    <= npc_q;
              npc_q   <= npc_inc;
              annul_q <= 1'b0;
            end else if (bus.is_call) begin
              disp_sel_q <= 1'b1;
              lat_a      <= 1'b0;
              lat_bicc   <= 1'b0;
              lat_cond   <= bus.cond;
              state      <= ST_CALC;
            end else if (bus.is_jmpl) begin
              pc_q    <= npc_q;
              npc_q   <= jmpl_aligned;
              annul_q <= 1'b0;
            end else if (bus.is_bicc && bicc_taken) begin
              disp_sel_q <= 1'b0;
              lat_a      <= bus.a_bit;
              lat_bicc   <= 1'b1;
              lat_cond   <= bus.cond;
              state      <= ST_CALC;
            end else if (bus.is_bicc) begin
              pc_q    <= npc_q;
              npc_q   <= npc_inc;
              annul_q <= bus.a_bit;
            end else begin
              pc_q    <= npc_q;
              npc_q   <= npc_inc;
              annul_q <= 1'b0;
            end
          end
        end
        ST_CALC: begin
          state    <= ST_WAIT;
          wait_cnt <= WAIT_LOAD;
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            // Only BA,a annuls on a taken branch; conditional taken ones run the slot.
            pc_q    <= npc_q;
            npc_q   <= bus.target;
            annul_q <= lat_a & lat_bicc & (lat_cond == 4'h8);
            state   <= ST_RUN;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign bus.ready    = (state == ST_RUN);
  assign bus.baux     = (state == ST_CALC);
  assign bus.disp_sel = disp_sel_q;
  assign bus.pc       = pc_q;
  assign bus.npc      = npc_q;
  assign bus.annul    = annul_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a timeline model of the PC/nPC rules checked
// every cycle, plus literal expectations at the scenario points.
module tb_branch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TGT_WAIT = 1;

  logic clk;
  logic rst;
  branch_sequencer_if bus ();

  branch_sequencer #(.RESET_PC(RESET_PC), .TGT_WAIT(TGT_WAIT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic run_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Spec-level condition table, one row per cond code.
  function automatic logic spec_taken(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      4'h0: return 1'b0;
      4'h1: return z;
      4'h2: return z || (n != v);
      4'h3: return n != v;
      4'h4: return cy || z;
      4'h5: return cy;
      4'h6: return n;
      4'h7: return v;
      4'h8: return 1'b1;
      4'h9: return !z;
      4'hA: return !(z || (n != v));
      4'hB: return n == v;
      4'hC: return !(cy || z);
      4'hD: return !cy;
      4'hE: return !n;
      default: return !v;
    endcase
  endfunction

  // Model: architectural PC/nPC/annul plus the number of cycles left busy.
  logic [31:0] m_pc, m_npc;
  logic        m_annul, m_disp, p_annul;
  int          m_rem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    <= RESET_PC;
      m_npc   <= RESET_PC + 32'd4;
      m_annul <= 1'b0;
      m_disp  <= 1'b0;
      p_annul <= 1'b0;
      m_rem   <= 0;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_pc    <= m_npc;
        m_npc   <= bus.target;
        m_annul <= p_annul;
      end
    end else if (bus.step) begin
      if (m_annul) begin
        m_pc <= m_npc; m_npc <= m_npc + 32'd4; m_annul <= 1'b0;
      end else if (bus.is_call) begin
        m_rem <= 1 + TGT_WAIT; p_annul <= 1'b0; m_disp <= 1'b1;
      end else if (bus.is_jmpl) begin
        m_pc <= m_npc; m_npc <= {bus.jmpl_target[31:2], 2'b00}; m_annul <= 1'b0;
      end else if (bus.is_bicc && spec_taken(bus.cond, bus.icc)) begin
        m_rem <= 1 + TGT_WAIT; p_annul <= bus.a_bit && (bus.cond == 4'h8); m_disp <= 1'b0;
      end else if (bus.is_bicc) begin
        m_pc <= m_npc; m_npc <= m_npc + 32'd4; m_annul <= bus.a_bit;
      end else begin
        m_pc <= m_npc; m_npc <= m_npc + 32'd4; m_annul <= 1'b0;
      end
    end
  end

  // Scoreboard compare on the falling edge.
  always @(negedge clk) begin
    if (run_chk && !rst) begin
      check("ready", {31'd0, bus.ready}, {31'd0, m_rem == 0});
      check("baux",  {31'd0, bus.baux},  {31'd0, m_rem == 1 + TGT_WAIT});
      check("pc",    bus.pc,  m_pc);
      check("npc",   bus.npc, m_npc);
      check("annul", {31'd0, bus.annul}, {31'd0, m_annul});
      if (m_rem != 0) check("disp_sel", {31'd0, bus.disp_sel}, {31'd0, m_disp});
    end
  end

  // driver tasks
  task automatic clear_inputs();
    bus.step = 1'b0; bus.is_bicc = 1'b0; bus.is_call = 1'b0; bus.is_jmpl = 1'b0;
    bus.cond = 4'h0; bus.a_bit = 1'b0; bus.icc = 4'h0; bus.jmpl_target = 32'h0;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (bus.ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (bus.ready !== 1'b1) check("ready_timeout", {31'd0, bus.ready}, 32'd1);
  endtask

  task automatic issue(input logic bicc, input logic call, input logic jmpl,
                       input logic [3:0] c, input logic a, input logic [3:0] f,
                       input logic [31:0] jt);
    bus.is_bicc = bicc; bus.is_call = call; bus.is_jmpl = jmpl;
    bus.cond = c; bus.a_bit = a; bus.icc = f; bus.jmpl_target = jt;
    bus.step = 1'b1;
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic plain();
    issue(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0);
    wait_ready();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #7;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    bus.target = 32'h0;
    #1;
    do_reset();
    run_chk = 1'b1;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_npc", bus.npc, 32'h4);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_state", {30'd0, bus.state}, 32'd0);

    // plain steps
    plain(); check("p1_pc", bus.pc, 32'h4);
    plain(); check("p2_pc", bus.pc, 32'h8); check("p2_npc", bus.npc, 32'hC);

    // BNE,a=0 with Z=0 at pc=8 -> taken to 0x40
    bus.target = 32'h40;
    issue(1'b1, 1'b0, 1'b0, 4'h9, 1'b0, 4'b0000, 32'h0);
    check("bne_baux", {31'd0, bus.baux}, 32'd1);
    check("bne_disp", {31'd0, bus.disp_sel}, 32'd0);
    wait_ready();
    check("bne_pc", bus.pc, 32'hC);
    check("bne_npc", bus.npc, 32'h40);
    check("bne_annul", {31'd0, bus.annul}, 32'd0);
    plain(); check("p3_pc", bus.pc, 32'h40);

    // BE,a=1 with Z=0 -> not taken, slot annulled
    issue(1'b1, 1'b0, 1'b0, 4'h1, 1'b1, 4'b0000, 32'h0);
    check("be_ready", {31'd0, bus.ready}, 32'd1);
    check("be_annul", {31'd0, bus.annul}, 32'd1);
    check("be_npc", bus.npc, 32'h48);
    issue(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 32'h0000_0800);
    check("sq_pc", bus.pc, 32'h48);
    check("sq_npc", bus.npc, 32'h4C);
    check("sq_annul", {31'd0, bus.annul}, 32'd0);

    // BA,a=1 -> taken, annul after capture; stray Bicc in the slot ignored
    bus.target = 32'h100;
    issue(1'b1, 1'b0, 1'b0, 4'h8, 1'b1, 4'b0000, 32'h0);
    wait_ready();
    check("ba_npc", bus.npc, 32'h100);
    check("ba_annul", {31'd0, bus.annul}, 32'd1);
    issue(1'b1, 1'b0, 1'b0, 4'h8, 1'b0, 4'b0000, 32'h0);
    check("ba_sq_pc", bus.pc, 32'h100);
    check("ba_sq_npc", bus.npc, 32'h104);
    check("ba_sq_ready", {31'd0, bus.ready}, 32'd1);

    // BG with N=1,V=1,Z=0 -> taken
    bus.target = 32'h500;
    issue(1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 4'b1010, 32'h0);
    wait_ready();
    check("bg_npc", bus.npc, 32'h500);
    plain();

    // JMPL: low target bits forced to zero
    issue(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 32'h0000_0023);
    check("jmpl_pc", bus.pc, 32'h504);
    check("jmpl_npc", bus.npc, 32'h20);
    plain();

    // CALL at 0x20 with stray step while busy; is_call beats is_jmpl/is_bicc
    bus.target = 32'h2000;
    issue(1'b1, 1'b1, 1'b1, 4'h8, 1'b1, 4'h0, 32'h0000_0444);
    check("call_baux", {31'd0, bus.baux}, 32'd1);
    check("call_disp", {31'd0, bus.disp_sel}, 32'd1);
    bus.step = 1'b1; bus.is_jmpl = 1'b1; bus.jmpl_target = 32'h0000_0600;
    @(posedge clk); #1;
    clear_inputs();
    check("call_hold_pc", bus.pc, 32'h20);
    wait_ready();
    check("call_pc", bus.pc, 32'h24);
    check("call_npc", bus.npc, 32'h2000);
    check("call_annul", {31'd0, bus.annul}, 32'd0);

    // every cond against several icc patterns, a=0
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 16; c++) begin
        logic [3:0] f;
        f = (p == 0) ? 4'b0000 : (p == 1) ? 4'b0100 : (p == 2) ? 4'b1001 : 4'b0010;
        bus.target = 32'h1000 + 32'(p * 256 + c * 16);
        issue(1'b1, 1'b0, 1'b0, 4'(c), 1'b0, f, 32'h0);
        wait_ready();
      end
    end

    // reset while waiting for the target
    bus.target = 32'h300;
    issue(1'b1, 1'b0, 1'b0, 4'h8, 1'b0, 4'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rw_baux", {31'd0, bus.baux}, 32'd0);
    check("rw_pc", bus.pc, RESET_PC);
    check("rw_npc", bus.npc, RESET_PC + 32'd4);
    check("rw_ready", {31'd0, bus.ready}, 32'd1);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // npc wrap at the top of the address space
    issue(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 32'hFFFF_FFF8);
    check("wr_npc0", bus.npc, 32'hFFFF_FFF8);
    plain(); check("wr_pc1", bus.pc, 32'hFFFF_FFF8); check("wr_npc1", bus.npc, 32'hFFFF_FFFC);
    plain(); check("wr_pc2", bus.pc, 32'hFFFF_FFFC); check("wr_npc2", bus.npc, 32'h0);
    plain(); check("wr_pc3", bus.pc, 32'h0); check("wr_npc3", bus.npc, 32'h4);

    @(posedge clk); #1;
    run_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
